// File: rtl/rca_4bit.sv
// Ripple-carry adder: {c_out,sum} = a + b + c_in through a chain of full-adder cells, plus a registered copy.
// Optional signed-overflow outputs ovf/ovf_q are built when RCA_4BIT_OVERFLOW_EN is defined.

module rca_4bit_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

module rca_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             c_out_q
`ifdef RCA_4BIT_OVERFLOW_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  logic [WIDTH:0] c;

  assign c[0] = c_in;

  // Carry ripples structurally; each cell only sees its neighbour's carry.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    rca_4bit_fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign c_out = c[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum;
      c_out_q <= c_out;
    end
  end

`ifdef RCA_4BIT_OVERFLOW_EN
  // Two's-complement overflow: carry into the sign bit differs from carry out of it.
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf;
  end
`endif

endmodule

// File: tb/tb_rca_4bit.sv
// Randomized + exhaustive bench for rca_4bit against an arithmetic reference model.
// Define RCA_4BIT_OVERFLOW_EN for both files to also check ovf/ovf_q.

module tb_rca_4bit;
  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b;
  logic         c_in;
  logic [W-1:0] sum, sum_q;
  logic         c_out, c_out_q;
`ifdef RCA_4BIT_OVERFLOW_EN
  logic         ovf, ovf_q;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  rca_4bit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .sum     (sum),
    .c_out   (c_out),
    .sum_q   (sum_q),
    .c_out_q (c_out_q)
`ifdef RCA_4BIT_OVERFLOW_EN
    ,
    .ovf     (ovf),
    .ovf_q   (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic.
  function automatic int add_full(input int x, input int y, input int ci);
    return x + y + ci;
  endfunction

  function automatic int to_signed(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic bit sovf(input int x, input int y, input int ci);
    int s;
    s = to_signed(x) + to_signed(y) + ci;
    return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Expected registered outputs, updated at the same edge the DUT registers update.
  int exp_q_total;
  bit exp_q_ovf;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    model_valid <= 1'b1;
    if (!rst_n) begin
      exp_q_total <= 0;
      exp_q_ovf   <= 1'b0;
    end else begin
      exp_q_total <= add_full(int'(a), int'(b), int'(c_in));
      exp_q_ovf   <= sovf(int'(a), int'(b), int'(c_in));
    end
  end

  // Continuous compare, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("comb_total", int'({c_out, sum}), add_full(int'(a), int'(b), int'(c_in)));
      check("reg_total", int'({c_out_q, sum_q}), exp_q_total);
`ifdef RCA_4BIT_OVERFLOW_EN
      check("comb_ovf", int'(ovf), int'(sovf(int'(a), int'(b), int'(c_in))));
      check("reg_ovf", int'(ovf_q), int'(exp_q_ovf));
`endif
    end
  end

  // Drive new inputs 2 time units after a rising edge.
  task automatic apply(input int av, input int bv, input int cv, input bit rv);
    @(posedge clk);
    #2;
    a     = W'(av);
    b     = W'(bv);
    c_in  = cv[0];
    rst_n = rv;
  endtask

  // Directed vector with hand-computed expectations.
  task automatic directed(input int av, input int bv, input int cv,
                          input int ws, input int wc, input int wo);
    apply(av, bv, cv, 1'b1);
    #1;
    check("dir_sum", int'(sum), ws);
    check("dir_cout", int'(c_out), wc);
`ifdef RCA_4BIT_OVERFLOW_EN
    check("dir_ovf", int'(ovf), wo);
`else
    if (wo < 0) check("dir_ovf_arg", wo, 0);
`endif
  endtask

  initial begin
    a = '0; b = '0; c_in = 1'b0; rst_n = 1'b0;
    apply(9, 6, 1, 1'b0);
    apply(9, 6, 1, 1'b0);
    #1;
    check("rst_sum_q", int'(sum_q), 0);
    check("rst_cout_q", int'(c_out_q), 0);
    check("rst_comb_sum", int'(sum), 0);
    check("rst_comb_cout", int'(c_out), 1);

    directed(15, 15, 1, 15, 1, 0);
    directed(10, 1, 1, 12, 0, 0);
    #1;
    check("lag_sum_q", int'(sum_q), 15);
    check("lag_cout_q", int'(c_out_q), 1);
    directed(5, 7, 0, 12, 0, 1);
    directed(3, 4, 1, 8, 0, 1);

    // Mid-stream reset with inputs held: registers clear, comb path unaffected.
    apply(3, 4, 1, 1'b0);
    @(posedge clk);
    #1;
    check("mid_rst_sum_q", int'(sum_q), 0);
    check("mid_rst_cout_q", int'(c_out_q), 0);
    check("mid_rst_sum", int'(sum), 8);
`ifdef RCA_4BIT_OVERFLOW_EN
    check("mid_rst_ovf_q", int'(ovf_q), 0);
`endif
    // First edge after release captures current inputs.
    apply(3, 4, 1, 1'b1);
    @(posedge clk);
    #1;
    check("release_sum_q", int'(sum_q), 8);

    // Exhaustive sweep.
    for (int ci = 0; ci < 2; ci++)
      for (int x = 0; x < (1 << W); x++)
        for (int y = 0; y < (1 << W); y++)
          apply(x, y, ci, 1'b1);

    // Random stimulus with occasional reset pulses.
    for (int k = 0; k < 400; k++)
      apply(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
            int'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));

    apply(0, 0, 0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
